sm_mult_pipe: RTL and testbench

SM_MULT_PIPE -- requirements
Module: sm_mult_pipe

---
 rtl/sm_mult_pipe_pkg.sv | 19 +
 rtl/sm_mult_lane.sv | 101 ++++++++++
 rtl/sm_mult_pipe.sv | 80 ++++++++
 tb/tb_sm_mult_pipe.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_mult_pipe_pkg.sv
// Shared definitions for the sign-magnitude fractional multiplier pipeline:
// operand code classes, rounding-mode encodings and a magnitude-limit helper.
package sm_mult_pipe_pkg;

  typedef enum logic [1:0] {
    CLS_ZERO   = 2'd0,
    CLS_UNIT   = 2'd1,
    CLS_NORMAL = 2'd2
  } cls_e;

  localparam logic RND_TRUNC   = 1'b0;
  localparam logic RND_HALF_UP = 1'b1;

  // Largest representable magnitude for a w-bit sign-magnitude word.
  function automatic int max_mag(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

endpackage

// File: rtl/sm_mult_lane.sv
// One multiplier lane: stage 1 classifies both operands and forms the full
// magnitude product; stage 2 rounds, saturates and packs the result word.
module sm_mult_lane
  import sm_mult_pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_p1,
  input  logic         en_p2,
  input  logic         rnd_p1,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] p,
  output logic         sat
);

  localparam int MW = W - 1;
  localparam int PW = 2 * W - 2;
  localparam logic [MW-1:0] MAG_MAX = MW'(max_mag(W));

  function automatic cls_e classify(input logic [W-1:0] x);
    cls_e c;
    c = CLS_NORMAL;
    if (x == '0) c = CLS_ZERO;
    else if (x[W-1] && (x[W-2:0] == '0)) c = CLS_UNIT;
    return c;
  endfunction

  // Returns {sat, magnitude}; the top bit of the sum is the overflow beyond MAG_MAX.
  function automatic logic [MW:0] round_mag(input logic [PW-1:0] prod, input logic rnd);
    logic [MW:0] sum;
    sum = {1'b0, prod[PW-1:MW]} + {{MW{1'b0}}, (rnd == RND_HALF_UP) & prod[MW-1]};
    if (sum[MW]) sum = {1'b1, MAG_MAX};
    return sum;
  endfunction

  cls_e          cls_a_c, cls_b_c;
  logic [PW-1:0] prod_c;
  logic [W-1:0]  pass_c;

  cls_e          cls_a_p1, cls_b_p1;
  logic          sgn_p1;
  logic [PW-1:0] prod_p1;
  logic [W-1:0]  pass_p1;

  logic          sat_c, sat_n;
  logic [MW-1:0] mag_c;
  logic [W-1:0]  res_c;

  logic [W-1:0]  p_p2;
  logic          sat_p2;

  assign cls_a_c = classify(a);
  assign cls_b_c = classify(b);
  assign prod_c  = PW'(a[MW-1:0]) * PW'(b[MW-1:0]);
  // A UNIT operand passes the other one through untouched.
  assign pass_c  = (cls_a_c == CLS_UNIT) ? b : a;

  // Stage 1 boundary: classes, product sign, raw product and pass-through word.
  always_ff @(posedge clk) begin
    if (en_p1) begin
      cls_a_p1 <= cls_a_c;
      cls_b_p1 <= cls_b_c;
      sgn_p1   <= a[W-1] ^ b[W-1];
      prod_p1  <= prod_c;
      pass_p1  <= pass_c;
    end
  end

  // Result selection; a zero magnitude always packs as all-zero, never UNIT or -0.
  always_comb begin
    {sat_c, mag_c} = round_mag(prod_p1, rnd_p1);
    res_c = '0;
    sat_n = 1'b0;
    if ((cls_a_p1 != CLS_ZERO) && (cls_b_p1 != CLS_ZERO)) begin
      if ((cls_a_p1 == CLS_UNIT) || (cls_b_p1 == CLS_UNIT)) begin
        res_c = pass_p1;
      end else if (mag_c != '0) begin
        res_c = {sgn_p1, mag_c};
        sat_n = sat_c;
      end
    end
  end

  // Stage 2 boundary: packed result and saturation flag, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_p2   <= '0;
      sat_p2 <= 1'b0;
    end else if (en_p2) begin
      p_p2   <= res_c;
      sat_p2 <= sat_n;
    end
  end

  assign p   = p_p2;
  assign sat = sat_p2;

endmodule

// File: rtl/sm_mult_pipe.sv
// Multi-lane sign-magnitude fractional multiplier with a two-stage
// valid/ready pipeline; all lanes share one handshake and one tag.
module sm_mult_pipe
  import sm_mult_pipe_pkg::*;
#(
  parameter int W     = 8,
  parameter int LANES = 4,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] in_a,
  input  logic [LANES*W-1:0] in_b,
  input  logic               in_rnd,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LANES*W-1:0] out_p,
  output logic [TAG_W-1:0]   out_tag,
  output logic [LANES-1:0]   out_sat
);

  logic             vld_p1, vld_p2;
  logic             s2_advance;
  logic             en_p1, en_p2;
  logic             rnd_p1;
  logic [TAG_W-1:0] tag_p1, tag_p2;

  // Stage 2 can take a new beat whenever it is empty or being drained;
  // stage 1 likewise whenever it is empty or moving forward.
  assign s2_advance = !vld_p2 || out_ready;
  assign in_ready   = !vld_p1 || s2_advance;
  assign en_p1      = in_valid && in_ready;
  assign en_p2      = vld_p1 && s2_advance;

  // Valid bits for both stages; reset discards anything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (in_ready)   vld_p1 <= in_valid;
      if (s2_advance) vld_p2 <= vld_p1;
    end
  end

  // Stage 1 boundary: per-beat rounding mode and tag captured on accept only.
  always_ff @(posedge clk) begin
    if (en_p1) begin
      rnd_p1 <= in_rnd;
      tag_p1 <= in_tag;
    end
  end

  // Stage 2 boundary: tag travels with the packed result.
  always_ff @(posedge clk) begin
    if (rst) tag_p2 <= '0;
    else if (en_p2) tag_p2 <= tag_p1;
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    sm_mult_lane #(.W(W)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .en_p1  (en_p1),
      .en_p2  (en_p2),
      .rnd_p1 (rnd_p1),
      .a      (in_a[k*W +: W]),
      .b      (in_b[k*W +: W]),
      .p      (out_p[k*W +: W]),
      .sat    (out_sat[k])
    );
  end

  assign out_valid = vld_p2;
  assign out_tag   = tag_p2;

endmodule

// File: tb/tb_sm_mult_pipe.sv
// Directed bench for sm_mult_pipe: a W=8 instance for function, handshake,
// stall and reset behaviour, and a W=4 instance for an exhaustive sweep.
module tb_sm_mult_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in8_valid, in8_ready, in8_rnd, out8_valid, out8_ready;
  logic [31:0] in8_a, in8_b, out8_p;
  logic [4:0]  in8_tag, out8_tag;
  logic [3:0]  out8_sat;

  logic        in4_valid, in4_ready, in4_rnd, out4_valid, out4_ready;
  logic [15:0] in4_a, in4_b, out4_p;
  logic [3:0]  in4_tag, out4_tag;
  logic [3:0]  out4_sat;

  sm_mult_pipe #(.W(8), .LANES(4), .TAG_W(5)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in8_valid), .in_ready(in8_ready),
    .in_a(in8_a), .in_b(in8_b), .in_rnd(in8_rnd), .in_tag(in8_tag),
    .out_valid(out8_valid), .out_ready(out8_ready), .out_p(out8_p),
    .out_tag(out8_tag), .out_sat(out8_sat)
  );

  sm_mult_pipe #(.W(4), .LANES(4), .TAG_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in4_valid), .in_ready(in4_ready),
    .in_a(in4_a), .in_b(in4_b), .in_rnd(in4_rnd), .in_tag(in4_tag),
    .out_valid(out4_valid), .out_ready(out4_ready), .out_p(out4_p),
    .out_tag(out4_tag), .out_sat(out4_sat)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Golden lane model working on integer values.
  function automatic int model_lane(input int w, input int a, input int b, input int rnd,
                                    output int sat);
    int mask, ma, mb, sa, sb, pr, m;
    mask = (1 << (w - 1)) - 1;
    ma = a & mask;
    mb = b & mask;
    sa = (a >> (w - 1)) & 1;
    sb = (b >> (w - 1)) & 1;
    sat = 0;
    if (a == 0 || b == 0) return 0;
    if (sa == 1 && ma == 0) return b;
    if (sb == 1 && mb == 0) return a;
    pr = ma * mb;
    m = pr >> (w - 1);
    if (rnd != 0) m = m + ((pr >> (w - 2)) & 1);
    if (m > mask) begin
      m = mask;
      sat = 1;
    end
    if (m == 0) return 0;
    return ((sa ^ sb) << (w - 1)) | m;
  endfunction

  function automatic void model_beat(input int w, input logic [31:0] av, input logic [31:0] bv,
                                     input logic rnd, output logic [31:0] pv, output logic [3:0] sv);
    logic [31:0] lmask;
    int s, r;
    lmask = (32'd1 << w) - 32'd1;
    pv = '0;
    sv = '0;
    for (int k = 0; k < 4; k++) begin
      r = model_lane(w, int'((av >> (k * w)) & lmask), int'((bv >> (k * w)) & lmask),
                     rnd ? 1 : 0, s);
      pv = pv | ((32'(r) & lmask) << (k * w));
      sv[k] = (s != 0);
    end
  endfunction

  task automatic drive8(input logic [31:0] a, input logic [31:0] b, input logic rnd,
                        input logic [4:0] tag);
    in8_valid = 1'b1;
    in8_a = a;
    in8_b = b;
    in8_rnd = rnd;
    in8_tag = tag;
  endtask

  logic [40:0] q8[$];
  logic [19:0] q4[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pv;
    logic [3:0]  sv;
    logic [40:0] e8;
    logic [19:0] e4;
    logic        hold;
    logic [31:0] hold_p;
    logic [4:0]  hold_tag;
    logic [8:0]  c9;
    int sent, got, cyc, idx, done4;

    rst = 1'b1;
    in8_valid = 0; in8_a = '0; in8_b = '0; in8_rnd = 0; in8_tag = '0; out8_ready = 1;
    in4_valid = 0; in4_a = '0; in4_b = '0; in4_rnd = 0; in4_tag = '0; out4_ready = 1;
    repeat (3) step();
    rst = 1'b0;
    #1;
    check("rst_vld", 32'(out8_valid), 0);
    check("rst_p", out8_p, 0);
    check("rst_tag", 32'(out8_tag), 0);
    check("rst_sat", 32'(out8_sat), 0);
    check("rst_rdy", 32'(in8_ready), 1);
    check("rst_vld4", 32'(out4_valid), 0);

    // Back-to-back directed beats, latency and order
    drive8(32'h80008040, 32'h8080C540, 1'b0, 5'd1);
    check("dir_rdy", 32'(in8_ready), 1);
    step();
    drive8(32'h03C5017F, 32'hD580817F, 1'b1, 5'd2);
    check("lat1_vld", 32'(out8_valid), 0);
    step();
    drive8(32'hC003FF01, 32'h40D57F81, 1'b0, 5'd3);
    check("lat2_vld", 32'(out8_valid), 1);
    check("dirA_p", out8_p, 32'h8000C520);
    check("dirA_tag", 32'(out8_tag), 1);
    check("dirA_sat", 32'(out8_sat), 0);
    step();
    in8_valid = 0;
    check("dirB_p", out8_p, 32'h82C5007E);
    check("dirB_tag", 32'(out8_tag), 2);
    check("dirB_sat", 32'(out8_sat), 0);
    step();
    check("dirC_p", out8_p, 32'hA081FE00);
    check("dirC_tag", 32'(out8_tag), 3);
    step();
    check("dir_empty", 32'(out8_valid), 0);

    // Stall: fill both stages with out_ready low, then release
    out8_ready = 0;
    drive8(32'h40404040, 32'h40404040, 1'b0, 5'd4);
    step();
    drive8(32'h7F7F7F7F, 32'h7F7F7F7F, 1'b1, 5'd5);
    step();
    drive8(32'h80808080, 32'hC5C5C5C5, 1'b0, 5'd6);
    check("stall_rdy", 32'(in8_ready), 0);
    check("stall_vld", 32'(out8_valid), 1);
    check("stall_p", out8_p, 32'h20202020);
    step();
    check("hold_p", out8_p, 32'h20202020);
    check("hold_tag", 32'(out8_tag), 4);
    check("hold_rdy", 32'(in8_ready), 0);
    out8_ready = 1;
    #1;
    check("rdy_comb", 32'(in8_ready), 1);
    step();
    in8_valid = 0;
    check("drainE_p", out8_p, 32'h7E7E7E7E);
    check("drainE_tag", 32'(out8_tag), 5);
    step();
    check("drainF_p", out8_p, 32'hC5C5C5C5);
    check("drainF_tag", 32'(out8_tag), 6);
    step();
    check("drain_empty", 32'(out8_valid), 0);

    // Reset with two beats in flight
    drive8(32'h40404040, 32'h40404040, 1'b0, 5'd7);
    step();
    drive8(32'h7F7F7F7F, 32'h7F7F7F7F, 1'b1, 5'd8);
    step();
    in8_valid = 0;
    rst = 1'b1;
    step();
    check("mrst_vld", 32'(out8_valid), 0);
    check("mrst_p", out8_p, 0);
    rst = 1'b0;
    #1;
    check("mrst_rdy", 32'(in8_ready), 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("mrst_stale", 32'(out8_valid), 0);
    end
    drive8(32'hC003FF01, 32'h40D57F81, 1'b0, 5'd9);
    step();
    in8_valid = 0;
    check("post_lat1", 32'(out8_valid), 0);
    step();
    check("post_lat2", 32'(out8_valid), 1);
    check("post_p", out8_p, 32'hA081FE00);
    check("post_tag", 32'(out8_tag), 9);
    step();

    // Random backpressure, 20 tagged beats
    sent = 0; got = 0; cyc = 0; hold = 0; hold_p = '0; hold_tag = '0;
    while (got < 20 && cyc < 3000) begin
      in8_valid = (sent < 20) && ($urandom_range(1) == 1);
      in8_a = $urandom();
      in8_b = $urandom();
      in8_rnd = 1'($urandom_range(1));
      in8_tag = 5'(sent);
      out8_ready = ($urandom_range(1) == 1);
      #1;
      if (hold) begin
        check("bp_hold_vld", 32'(out8_valid), 1);
        check("bp_hold_p", out8_p, hold_p);
        check("bp_hold_tag", 32'(out8_tag), 32'(hold_tag));
      end
      if (in8_valid && in8_ready) begin
        model_beat(8, in8_a, in8_b, in8_rnd, pv, sv);
        q8.push_back({in8_tag, sv, pv});
        sent++;
      end
      if (out8_valid && out8_ready) begin
        if (q8.size() == 0) begin
          check("bp_spurious", 1, 0);
        end else begin
          e8 = q8.pop_front();
          check("bp_tag", 32'(out8_tag), 32'(got));
          check("bp_p", out8_p, e8[31:0]);
          check("bp_sat", 32'(out8_sat), 32'(e8[35:32]));
        end
        got++;
      end
      hold = out8_valid && !out8_ready;
      hold_p = out8_p;
      hold_tag = out8_tag;
      step();
      cyc++;
    end
    in8_valid = 0;
    out8_ready = 1;
    check("bp_count", 32'(got), 20);

    // W=4 directed beat
    in4_valid = 1; in4_a = 16'h18F7; in4_b = 16'h1377; in4_rnd = 1; in4_tag = 4'd3;
    step();
    in4_valid = 0;
    check("w4_lat1", 32'(out4_valid), 0);
    step();
    check("w4_vld", 32'(out4_valid), 1);
    check("w4_p", 32'(out4_p), 32'h03E6);
    check("w4_sat", 32'(out4_sat), 0);
    step();

    // W=4 exhaustive sweep, both rounding modes
    idx = 0; done4 = 0; cyc = 0;
    while (done4 < 128 && cyc < 2000) begin
      if (idx < 512) begin
        in4_valid = 1;
        for (int k = 0; k < 4; k++) begin
          c9 = 9'(idx + k);
          in4_a[k*4 +: 4] = c9[7:4];
          in4_b[k*4 +: 4] = c9[3:0];
          in4_rnd = c9[8];
        end
        in4_tag = 4'(idx >> 2);
      end else begin
        in4_valid = 0;
      end
      #1;
      if (in4_valid && in4_ready) begin
        model_beat(4, 32'(in4_a), 32'(in4_b), in4_rnd, pv, sv);
        q4.push_back({sv, pv[15:0]});
        idx += 4;
      end
      if (out4_valid) begin
        if (q4.size() == 0) begin
          check("sw_spurious", 1, 0);
        end else begin
          e4 = q4.pop_front();
          check("sw_p", 32'(out4_p), 32'(e4[15:0]));
          check("sw_sat", 32'(out4_sat), 32'(e4[19:16]));
        end
        done4++;
      end
      step();
      cyc++;
    end
    in4_valid = 0;
    check("sw_count", 32'(done4), 128);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
